addsub_7seg_scan: RTL

Parametrised signed adder/subtractor with a multiplexed multi-digit 7-segment readout. It replaces the fixed 4-bit combinational add/sub-to-single-digit path with a sequential block. The block latches operands on a start strobe, computes a WIDTH-bit two's-complement sum or difference with an overflow flag, and converts the magnitude to BCD by shift-and-add-3. It then drives a time-multiplexed DIGITS-digit display with a sign digit. The block sits between the operand switches/register file and the board display pins.

---
 rtl/addsub_7seg_pkg.sv | 42 ++++
 rtl/addsub_7seg_scan_seg7_decode.sv | 19 +
 rtl/addsub_7seg_scan.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_7seg_pkg.sv
// -----------------------------------------------------------------------------
// addsub_7seg_pkg
// Shared definitions for the add/sub 7-segment readout block:
//   - state_t       : controller states (IDLE, CALC, CONV, FIN)
//   - SEG_BLANK     : all segments off
//   - SEG_MINUS     : segment g only, used as the sign digit
//   - HEX_SEG_TABLE : hex nibble to segment pattern, seg[0]=a .. seg[6]=g,
//                     active-high
// -----------------------------------------------------------------------------
package addsub_7seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_CONV = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;

    // Entry [n] is the pattern for nibble n; the list runs F down to 0.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

endpackage

// File: rtl/addsub_7seg_scan_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational hex nibble to 7-segment pattern decoder.
//   nibble : 4-bit value to display
//   seg    : active-high segment pattern, seg[0]=a .. seg[6]=g
// -----------------------------------------------------------------------------
module seg7_decode
    import addsub_7seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern
    always_comb begin
        seg = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/addsub_7seg_scan.sv
// -----------------------------------------------------------------------------
// addsub_7seg_scan
// Signed WIDTH-bit adder/subtractor feeding a time-multiplexed DIGITS-digit
// 7-segment display. Operands are latched on start; the result magnitude is
// converted to BCD by shift-and-add-3 (one bit per cycle) and shown with a
// sign digit in the most significant position.
//
// Ports:
//   clk, rst : clock (rising edge), synchronous active-high reset
//   a, b, s  : signed operands and operation select (0 = a+b, 1 = a-b)
//   start    : request, only sampled while idle
//   busy     : high during CALC and CONV
//   done     : one-cycle pulse when the displayed result updates
//   ovf      : signed overflow of the last completed operation
//   seg, an  : segment pattern and one-hot digit enable (an[0] = LS digit)
//
// Build option ADDSUB_7SEG_HEX_EN: skip BCD conversion and show the raw
// two's-complement result in hex (sign digit always blank).
// -----------------------------------------------------------------------------
module addsub_7seg_scan
    import addsub_7seg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              s,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int BCD_W = (DIGITS - 1) * 4;
    localparam int CNT_W = $clog2(WIDTH);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Controller state
    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               s_r;
    logic [WIDTH-1:0]   mag_r;
    logic               neg_r;
    logic               ovf_pend_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic               ovf_r;
    logic [BCD_W-1:0]   disp_r;
    logic               disp_neg_r;

    // Scan state
    logic [PRE_W-1:0]   pre_r;
    logic [IDX_W-1:0]   idx_r;
    logic [DIGITS-1:0]  an_r;
    logic [6:0]         seg_r;

    // Combinational datapath
    logic [WIDTH-1:0]       b_eff_s;
    logic [WIDTH-1:0]       r_s;
    logic                   ovf_s;
    logic [WIDTH-1:0]       mag_s;
    logic [BCD_W-1:0]       bcd_adj_s;
    logic [BCD_W+WIDTH-1:0] cat_s;
    logic [BCD_W+WIDTH-1:0] shift_s;
    logic [BCD_W-1:0]       bcd_next_s;
    logic [WIDTH-1:0]       mag_next_s;
    logic [3:0]             nibble_s;
    logic [6:0]             dec_s;
    logic [6:0]             seg_sel_s;
`ifdef ADDSUB_7SEG_HEX_EN
    logic [BCD_W-1:0]       hex_s;
`endif

    // Add/subtract, signed overflow and sign/magnitude split
    always_comb begin
        if (s_r) begin
            b_eff_s = ~b_r + WIDTH'(1);
        end else begin
            b_eff_s = b_r;
        end
        r_s   = a_r + b_eff_s;
        ovf_s = (a_r[WIDTH-1] == b_eff_s[WIDTH-1]) && (r_s[WIDTH-1] != a_r[WIDTH-1]);
        // Most negative value negates to itself, which read unsigned is 2^(WIDTH-1)
        if (r_s[WIDTH-1]) begin
            mag_s = ~r_s + WIDTH'(1);
        end else begin
            mag_s = r_s;
        end
    end

`ifdef ADDSUB_7SEG_HEX_EN
    // Raw result zero-extended onto the digit nibbles
    always_comb begin
        hex_s = BCD_W'(r_s);
    end
`endif

    // One double-dabble step: add 3 to each nibble >= 5, then shift in the next magnitude bit
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
        cat_s      = {bcd_adj_s, mag_r};
        shift_s    = {cat_s[BCD_W+WIDTH-2:0], 1'b0};
        bcd_next_s = shift_s[BCD_W+WIDTH-1:WIDTH];
        mag_next_s = shift_s[WIDTH-1:0];
    end

    // Controller: operand latch, calculation, conversion and display load
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            a_r        <= '0;
            b_r        <= '0;
            s_r        <= 1'b0;
            mag_r      <= '0;
            neg_r      <= 1'b0;
            ovf_pend_r <= 1'b0;
            bcd_r      <= '0;
            cnt_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
            disp_r     <= '0;
            disp_neg_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        s_r     <= s;
                        busy_r  <= 1'b1;
                        state_r <= ST_CALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    mag_r      <= mag_s;
                    neg_r      <= r_s[WIDTH-1];
                    ovf_pend_r <= ovf_s;
                    bcd_r      <= '0;
                    cnt_r      <= '0;
`ifdef ADDSUB_7SEG_HEX_EN
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    ovf_r      <= ovf_s;
                    disp_r     <= hex_s;
                    disp_neg_r <= 1'b0;
                    state_r    <= ST_FIN;
`else
                    state_r    <= ST_CONV;
`endif
                end
                ST_CONV: begin
                    bcd_r <= bcd_next_s;
                    mag_r <= mag_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    // Display loads with the final step's result so done and
                    // the new digits appear in the same cycle
                    if (cnt_r == CNT_LAST) begin
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        ovf_r      <= ovf_pend_r;
                        disp_r     <= bcd_next_s;
                        disp_neg_r <= neg_r;
                        state_r    <= ST_FIN;
                    end else begin
                        state_r <= ST_CONV;
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Scan mux: pick the nibble (or sign pattern) for the current digit index
    always_comb begin
        nibble_s = 4'd0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (idx_r == IDX_W'(i)) begin
                nibble_s = disp_r[4*i +: 4];
            end else begin
                nibble_s = nibble_s;
            end
        end
        if (idx_r == IDX_LAST) begin
            if (disp_neg_r) begin
                seg_sel_s = SEG_MINUS;
            end else begin
                seg_sel_s = SEG_BLANK;
            end
        end else begin
            seg_sel_s = dec_s;
        end
    end

    seg7_decode u_decode (
        .nibble (nibble_s),
        .seg    (dec_s)
    );

    // Free-running prescaler, digit index and registered display drive
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= '0;
            idx_r <= '0;
            an_r  <= DIGITS'(1'b1);
            seg_r <= HEX_SEG_TABLE[4'd0];
        end else begin
            if (pre_r == PRE_LAST) begin
                pre_r <= '0;
                if (idx_r == IDX_LAST) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                pre_r <= pre_r + PRE_W'(1);
                idx_r <= idx_r;
            end
            an_r  <= DIGITS'(1'b1) << idx_r;
            seg_r <= seg_sel_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign ovf  = ovf_r;
    assign seg  = seg_r;
    assign an   = an_r;

endmodule
